peak_finder: RTL and testbench

Pulse peak extractor sitting directly downstream of a filter stage (v1..v6) in the filter chain. It watches the signed filter output, detects threshold crossings with hysteresis, and tracks the maximum sample of each pulse. On pulse end it emits one registered record: amplitude, timestamp of the maximum, and width. A programmable hold-off follows each record, and any pulses lost during hold-off are counted.

---
 rtl/package_settings.sv | 7 +
 rtl/peak_finder_if.sv | 31 +++
 rtl/peak_timestamp_counter.sv | 15 +
 rtl/peak_finder.sv | 111 +++++++++++
 tb/tb_peak_finder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/package_settings.sv
// package_settings: shared sizes and FSM state type for the peak_finder filter-chain block
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int SIZE_PEAK_TIME = 32;
  localparam int SIZE_PEAK_CNT = 16;
  typedef enum logic [1:0] {IDLE, PULSE, REPORT, HOLDOFF} peak_state_t;
endpackage

// File: rtl/peak_finder_if.sv
// peak_finder_if: sample stream in, pulse records and status out
//   input_data  signed filter sample, one per clock
//   threshold   signed trigger level
//   hysteresis  unsigned drop below threshold that ends a pulse
//   peak_valid  one-cycle record strobe
//   peak_amplitude / peak_time / pulse_width  record fields
//   event_count / lost_count / busy           status
// The slave modport is the peak_finder side, the master modport the sample source / record sink.
interface peak_finder_if #(
  parameter int DATA_W = package_settings::SIZE_FILTER_DATA,
  parameter int TIME_W = package_settings::SIZE_PEAK_TIME
);
  logic [DATA_W-1:0] input_data;
  logic [DATA_W-1:0] threshold;
  logic [DATA_W-1:0] hysteresis;
  logic peak_valid;
  logic [DATA_W-1:0] peak_amplitude;
  logic [TIME_W-1:0] peak_time;
  logic [package_settings::SIZE_PEAK_CNT-1:0] pulse_width;
  logic [package_settings::SIZE_PEAK_CNT-1:0] event_count;
  logic [package_settings::SIZE_PEAK_CNT-1:0] lost_count;
  logic busy;
  modport slave (
    input  input_data, threshold, hysteresis,
    output peak_valid, peak_amplitude, peak_time, pulse_width, event_count, lost_count, busy
  );
  modport master (
    output input_data, threshold, hysteresis,
    input  peak_valid, peak_amplitude, peak_time, pulse_width, event_count, lost_count, busy
  );
endinterface

// File: rtl/peak_timestamp_counter.sv
// peak_timestamp_counter: free-running wrapping counter, async active-low reset
//   clk    clock
//   reset  asynchronous active-low reset, clears count
//   count  current value; the value seen at an edge is the timestamp of the sample taken there
module peak_timestamp_counter #(
  parameter int W = package_settings::SIZE_PEAK_TIME
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= count + 1'b1;
endmodule

// File: rtl/peak_finder.sv
// peak_finder: threshold/hysteresis pulse detector emitting max amplitude, its timestamp and width
//   clk    system clock, one sample per cycle
//   reset  asynchronous active-low reset; clears state, records and counters
//   pk     peak_finder_if slave: samples, levels, record outputs, event/lost counters, busy
module peak_finder #(
  parameter int DATA_W  = package_settings::SIZE_FILTER_DATA,
  parameter int TIME_W  = package_settings::SIZE_PEAK_TIME,
  parameter int HOLDOFF = 8
) (
  input  logic clk,
  input  logic reset,
  peak_finder_if.slave pk
);
  localparam int CW = package_settings::SIZE_PEAK_CNT;
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  package_settings::peak_state_t state;
  logic [TIME_W-1:0] ts;
  logic [TIME_W-1:0] max_time;
  logic [TIME_W-1:0] time_q;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] thr;
  logic signed [DATA_W-1:0] max_amp;
  logic signed [DATA_W-1:0] amp_q;
  logic signed [DATA_W:0] x_e;
  logic signed [DATA_W:0] lo;
  logic above;
  logic above_q;
  logic below;
  logic valid_q;
  logic [CW-1:0] width;
  logic [CW-1:0] width_q;
  logic [CW-1:0] event_q;
  logic [CW-1:0] lost_q;
  logic [HW-1:0] hcnt;

  peak_timestamp_counter #(.W(TIME_W)) u_ts (
    .clk   (clk),
    .reset (reset),
    .count (ts)
  );

  // Exit level is formed one bit wider so a large hysteresis below a negative threshold cannot wrap.
  assign x     = pk.input_data;
  assign thr   = pk.threshold;
  assign x_e   = {x[DATA_W-1], x};
  assign lo    = {thr[DATA_W-1], thr} - $signed({1'b0, pk.hysteresis});
  assign above = x > thr;
  assign below = x_e < lo;

  assign pk.peak_valid     = valid_q;
  assign pk.peak_amplitude = amp_q;
  assign pk.peak_time      = time_q;
  assign pk.pulse_width    = width_q;
  assign pk.event_count    = event_q;
  assign pk.lost_count     = lost_q;
  assign pk.busy           = state != package_settings::IDLE;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= package_settings::IDLE;
      max_amp  <= '0;
      max_time <= '0;
      width    <= '0;
      amp_q    <= '0;
      time_q   <= '0;
      width_q  <= '0;
      event_q  <= '0;
      lost_q   <= '0;
      valid_q  <= 1'b0;
      above_q  <= 1'b0;
      hcnt     <= '0;
    end else begin
      above_q <= above;
      valid_q <= 1'b0;
      unique case (state)
        package_settings::IDLE:
          if (above) begin
            state    <= package_settings::PULSE;
            max_amp  <= x;
            max_time <= ts;
            width    <= CW'(1);
          end
        package_settings::PULSE:
          if (below) state <= package_settings::REPORT;
          else begin
            width <= width + CW'(width != '1);
            // strict compare keeps the earliest of equal maxima
            if (x > max_amp) begin
              max_amp  <= x;
              max_time <= ts;
            end
          end
        package_settings::REPORT: begin
          amp_q   <= max_amp;
          time_q  <= max_time;
          width_q <= width;
          valid_q <= 1'b1;
          event_q <= event_q + 1'b1;
          hcnt    <= '0;
          state   <= HOLDOFF == 0 ? package_settings::IDLE : package_settings::HOLDOFF;
        end
        package_settings::HOLDOFF: begin
          // above_q holds the previous sample, so a level already high on entry is not a crossing
          if (above && !above_q) lost_q <= lost_q + CW'(lost_q != '1);
          hcnt <= hcnt + 1'b1;
          if (hcnt == H_LAST) state <= package_settings::IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_peak_finder.sv
module tb_peak_finder;
  typedef struct {
    longint amp;
    longint tm;
    longint w;
    longint ev;
    longint at;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  rec_t sb[$];

  peak_finder_if #(.DATA_W(16), .TIME_W(32)) pk ();

  peak_finder #(.DATA_W(16), .TIME_W(32), .HOLDOFF(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pk    (pk.slave)
  );

  always #5 clk = ~clk;

  // cyc = number of edges since reset release; record strobe from edge t is seen with cyc = t+1
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && pk.peak_valid) begin
      if (sb.size() == 0) chk("unexpected_strobe", cyc, -1);
      else begin
        rec_t e;
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.at);
        chk("amplitude", longint'($signed(pk.peak_amplitude)), e.amp);
        chk("peak_time", longint'(pk.peak_time), e.tm);
        chk("pulse_width", longint'(pk.pulse_width), e.w);
        chk("event_count", longint'(pk.event_count), e.ev);
      end
    end

  task automatic expect_rec(input longint amp, input longint tm, input longint w, input longint ev, input longint at);
    rec_t r;
    r.amp = amp; r.tm = tm; r.w = w; r.ev = ev; r.at = at;
    sb.push_back(r);
  endtask

  task automatic step(input int v, input int n = 1);
    repeat (n) begin
      pk.input_data = 16'(v);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int thr, input int hyst);
    reset = 1'b0;
    pk.input_data = '0;
    pk.threshold = 16'(thr);
    pk.hysteresis = 16'(hyst);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_drained(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step(0);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  int tri_v[10] = '{0, 50, 120, 200, 300, 250, 150, 95, 80, 0};
  int eq_v[4] = '{150, 300, 300, 50};
  int pile_v[14] = '{0, 200, 0, 0, 0, 0, 200, 0, 0, 0, 0, 0, 150, 0};

  initial begin
    do_reset(100, 10);
    #1;
    chk("rst_valid", pk.peak_valid, 0);
    chk("rst_amp", pk.peak_amplitude, 0);
    chk("rst_time", pk.peak_time, 0);
    chk("rst_width", pk.pulse_width, 0);
    chk("rst_events", pk.event_count, 0);
    chk("rst_lost", pk.lost_count, 0);
    chk("rst_busy", pk.busy, 0);
    @(negedge clk);
    do_reset(100, 10);

    // triangle: max 300 at t=4, width 6 (t2..t7), exit at t=8, strobe after edge t=9
    expect_rec(300, 4, 6, 1, 10);
    for (int i = 0; i < 10; i++) begin
      step(tri_v[i]);
      if (i == 7) chk("hyst_keeps_pulse", pk.busy, 1);
    end
    step(0, 4);
    chk_drained("triangle_drained");
    chk("record_held_amp", longint'($signed(pk.peak_amplitude)), 300);
    chk("record_held_valid", pk.peak_valid, 0);
    chk("triangle_lost", pk.lost_count, 0);

    // equal maxima: first 300 at t=1 wins
    do_reset(100, 10);
    expect_rec(300, 1, 3, 1, 5);
    foreach (eq_v[i]) step(eq_v[i]);
    chk_drained("equal_drained");

    // pile-up: REPORT at edge 3, crossing at t=6 lost, pulse at t=12 (first IDLE) reported
    do_reset(100, 10);
    expect_rec(200, 1, 1, 1, 4);
    expect_rec(150, 12, 1, 2, 15);
    foreach (pile_v[i]) step(pile_v[i]);
    chk_drained("pileup_drained");
    chk("pileup_lost", pk.lost_count, 1);
    chk("pileup_events", pk.event_count, 2);

    // level held high through hold-off: not a crossing, but starts a pulse in first IDLE cycle (t=11)
    do_reset(100, 10);
    expect_rec(200, 0, 1, 1, 3);
    expect_rec(200, 11, 1, 2, 14);
    step(200);
    step(0);
    step(200, 10);
    step(0);
    chk_drained("held_drained");
    chk("held_lost", pk.lost_count, 0);

    // negative threshold, small hysteresis: lo = -60, -55 stays, -61 exits
    do_reset(-50, 10);
    expect_rec(0, 1, 2, 1, 5);
    step(-100);
    step(0);
    step(-55);
    step(-61);
    step(-100);
    chk_drained("neg_drained");

    // lo = -50 - 32767 needs 17 bits; minimum sample must not end the pulse
    do_reset(-50, 16'h7FFF);
    step(0);
    step(-32768, 20);
    chk("neg_no_exit", pk.busy, 1);
    chk("neg_no_event", pk.event_count, 0);

    // asynchronous reset mid-pulse after one recorded event
    do_reset(100, 10);
    expect_rec(200, 0, 1, 1, 3);
    step(200);
    step(0, 12);
    step(200);
    step(250);
    chk("mid_busy", pk.busy, 1);
    chk("mid_events", pk.event_count, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", pk.busy, 0);
    chk("async_amp", pk.peak_amplitude, 0);
    chk("async_events", pk.event_count, 0);
    chk("async_width", pk.pulse_width, 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 15);
    chk("after_rst_events", pk.event_count, 0);
    chk("after_rst_sb", sb.size(), 0);

    // width saturation over a 70000-sample pulse
    do_reset(100, 10);
    expect_rec(200, 0, 16'hFFFF, 1, 70002);
    step(200, 70000);
    step(0);
    chk_drained("sat_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
